regfile_ctrl: RTL

REGFILE_CTRL -- requirements
Module: regfile_ctrl

---
 rtl/regfile_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequences LOADI/MOV/ADD/READ commands against an external 4-entry register file.
// Revision 1.0 - initial release.
`default_nettype none

module regfile_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [1:0]        cmd_dst,
   input  logic [1:0]        cmd_src,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [1:0]        rf_write_address,
   output logic              rf_write_enable,
   output logic [1:0]        rf_read_address,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              carry,
   output logic              busy
);

   localparam logic [1:0] OP_LOADI = 2'b00;
   localparam logic [1:0] OP_MOV   = 2'b01;
   localparam logic [1:0] OP_ADD   = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_A  = 3'd1,
      RD_B  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [1:0]        dst_q, dst_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
   logic [1:0]        rf_write_address_q, rf_write_address_d;
   logic              rf_write_enable_q, rf_write_enable_d;
   logic [1:0]        rf_read_address_q, rf_read_address_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              carry_q, carry_d;
   logic [DATA_W:0]   sum;

   // One adder: B comes live from the file in RD_B, from the latched copy in WRITE for the carry.
   assign sum = {1'b0, a_q} + {1'b0, (state_q == RD_B) ? rf_read_data : b_q};

   always_comb begin
      state_d            = state_q;
      op_d               = op_q;
      dst_d              = dst_q;
      a_d                = a_q;
      b_d                = b_q;
      rf_write_data_d    = rf_write_data_q;
      rf_write_address_d = rf_write_address_q;
      rf_write_enable_d  = 1'b0;
      rf_read_address_d  = rf_read_address_q;
      rsp_valid_d        = rsp_valid_q;
      rsp_data_d         = rsp_data_q;
      carry_d            = carry_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d  = cmd_op;
               dst_d = cmd_dst;
               if (cmd_op == OP_LOADI) begin
                  state_d            = WRITE;
                  rf_write_enable_d  = 1'b1;
                  rf_write_address_d = cmd_dst;
                  rf_write_data_d    = cmd_imm;
               end else begin
                  state_d           = RD_A;
                  rf_read_address_d = cmd_src;
               end
            end
         end
         RD_A: begin
            a_d = rf_read_data;
            case (op_q)
               OP_MOV: begin
                  state_d            = WRITE;
                  rf_write_enable_d  = 1'b1;
                  rf_write_address_d = dst_q;
                  rf_write_data_d    = rf_read_data;
               end
               OP_ADD: begin
                  state_d           = RD_B;
                  rf_read_address_d = dst_q;
               end
               default: begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = rf_read_data;
               end
            endcase
         end
         RD_B: begin
            b_d                = rf_read_data;
            state_d            = WRITE;
            rf_write_enable_d  = 1'b1;
            rf_write_address_d = dst_q;
            rf_write_data_d    = sum[DATA_W-1:0];
         end
         WRITE: begin
            state_d = IDLE;
            if (op_q == OP_ADD) begin
               carry_d = sum[DATA_W];
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q            <= IDLE;
         op_q               <= '0;
         dst_q              <= '0;
         a_q                <= '0;
         b_q                <= '0;
         rf_write_data_q    <= '0;
         rf_write_address_q <= '0;
         rf_write_enable_q  <= 1'b0;
         rf_read_address_q  <= '0;
         rsp_valid_q        <= 1'b0;
         rsp_data_q         <= '0;
         carry_q            <= 1'b0;
      end else begin
         state_q            <= state_d;
         op_q               <= op_d;
         dst_q              <= dst_d;
         a_q                <= a_d;
         b_q                <= b_d;
         rf_write_data_q    <= rf_write_data_d;
         rf_write_address_q <= rf_write_address_d;
         rf_write_enable_q  <= rf_write_enable_d;
         rf_read_address_q  <= rf_read_address_d;
         rsp_valid_q        <= rsp_valid_d;
         rsp_data_q         <= rsp_data_d;
         carry_q            <= carry_d;
      end
   end

   assign cmd_ready        = (state_q == IDLE) && !rsp_valid_q;
   assign busy             = (state_q != IDLE);
   assign rf_write_data    = rf_write_data_q;
   assign rf_write_address = rf_write_address_q;
   assign rf_write_enable  = rf_write_enable_q;
   assign rf_read_address  = rf_read_address_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_data         = rsp_data_q;
   assign carry            = carry_q;

endmodule

`default_nettype wire
